run_monitor: RTL and testbench
==============================

// Module: run_monitor
// PURPOSE
//  Synthesizable run-control and hang detector for the pipelined RV32 core, for FPGA and sim.
//  Watches NCH stage PCs (e.g. ID/EX/MEM) for lack of progress, counts run cycles, and
//  latches the first terminating event (EBREAK, ECALL, stuck PC, global timeout) with its PC.
//  Sits beside top; debug/UART logic reads the halt record.
// PARAMETERS
//  XLEN        32     PC width
//  NCH         3      number of watched PC channels
//  STUCK_W     24     per-channel stuck counter width
//  STUCK_LIMIT 2000000 cycles a channel PC may stay unchanged before halt; 0 = detection off
//  CYC_W       64     cycle counter width
//  TIMEOUT     0      run-cycle limit; 0 = timeout off
//  (localparam CH_W = NCH>1 ? $clog2(NCH) : 1)
// PORTS
//  clk          in   1          clock
//  rst          in   1          synchronous, active-high reset
//  start        in   1          pulse: IDLE -> RUN
//  clear        in   1          pulse: HALTED -> IDLE
//  ch_pc        in   NCH*XLEN   channel i PC at [i*XLEN +: XLEN]
//  ch_valid     in   NCH        channel i holds a real instruction this cycle
//  ecall_pulse  in   1          core retired ECALL
//  ebreak_pulse in   1          core retired EBREAK
//  ev_pc        in   XLEN       PC of the ECALL/EBREAK
//  running      out  1          state == RUN
//  halted       out  1          state == HALTED
//  halt_pulse   out  1          1-cycle strobe on entry to HALTED
//  halt_cause   out  3          0 none,1 ECALL,2 EBREAK,3 STUCK,4 TIMEOUT
//  halt_ch      out  CH_W       channel that tripped STUCK, else 0
//  halt_pc      out  XLEN       PC associated with the cause
//  cycle_count  out  CYC_W      RUN cycles since last start
// BEHAVIOUR
//  - Reset: state IDLE; all outputs 0; last_pc[i]=0, stuck_cnt[i]=0. rst mid-RUN aborts, no halt record.
//  - IDLE: start -> RUN next cycle; cycle_count, stuck_cnt[], last_pc[] cleared on that edge.
//    halt_cause/ch/pc retained from previous run until start.
//  - RUN, each cycle: cycle_count+1, saturating at all-ones.
//    Per channel: valid && pc!=last_pc -> last_pc<=pc, cnt<=0;
//    valid && pc==last_pc, or !valid (bubble/stall) -> cnt+1, saturating.
//  - Trip conditions, evaluated on current-cycle inputs/regs in RUN:
//    EBREAK: ebreak_pulse. ECALL: ecall_pulse.
//    STUCK: STUCK_LIMIT!=0 && stuck_cnt[i]==STUCK_LIMIT-1 && no progress on ch i this cycle.
//    TIMEOUT: TIMEOUT!=0 && cycle_count==TIMEOUT-1.
//  - Priority for simultaneous trips: EBREAK > ECALL > STUCK (lowest i) > TIMEOUT.
//  - On trip edge: state<=HALTED, halt_pulse<=1 for one cycle, cause/ch/pc latched.
//    halted is 1 the cycle after the trip.
//    halt_pc: ev_pc for ECALL/EBREAK; last_pc[i] for STUCK; ch_pc[0] for TIMEOUT.
//    The tripping cycle is counted in cycle_count.
//  - HALTED: counters frozen; all event inputs ignored; start ignored.
//    clear -> IDLE; start and clear same cycle -> clear wins.
//  - start in RUN and clear in IDLE/RUN are no-ops.
//  - Events outside RUN never latch.
//  - STUCK_LIMIT larger than 2^STUCK_W-1: illegal, elaboration $error.
// TESTING
//  1 start; ch0 pc 0,4,8,... every cycle; ebreak_pulse with ev_pc=0x80 on RUN cycle 10
//    -> halted next cycle, cause=2, halt_pc=0x80, cycle_count=10.
//  2 STUCK_LIMIT=16; ch1 pc held at 0x1000 from RUN cycle 3, ch0 progressing
//    -> cause=3, halt_ch=1, halt_pc=0x1000, halt_pulse exactly one cycle.
//  3 ecall_pulse and ebreak_pulse same cycle, plus a stuck trip on ch0 in that cycle
//    -> cause=2 (EBREAK).
//  4 TIMEOUT=100, STUCK_LIMIT=0, PCs frozen -> cause=4 at cycle_count=100; no STUCK trip.
//  5 ch0 valid=0 for 15 cycles then new PC, STUCK_LIMIT=16 -> no halt; counter resets.
//  6 rst asserted mid-RUN -> next cycle all outputs 0, state IDLE.
//    clear+start same cycle in HALTED -> IDLE, record kept until the next start.

Source files
------------

// File: rtl/run_monitor.sv
// Run-control and hang detector: watches per-channel PC progress, counts run cycles and
// latches the first terminating event (EBREAK, ECALL, stuck PC, timeout) with its PC.
module run_monitor #(
  parameter int unsigned     XLEN        = 32,
  parameter int unsigned     NCH         = 3,
  parameter int unsigned     STUCK_W     = 24,
  parameter longint unsigned STUCK_LIMIT = 2000000,
  parameter int unsigned     CYC_W       = 64,
  parameter longint unsigned TIMEOUT     = 0,
  localparam int unsigned    CH_W        = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                clear,
  input  logic [NCH*XLEN-1:0] ch_pc,
  input  logic [NCH-1:0]      ch_valid,
  input  logic                ecall_pulse,
  input  logic                ebreak_pulse,
  input  logic [XLEN-1:0]     ev_pc,
  output logic                running,
  output logic                halted,
  output logic                halt_pulse,
  output logic [2:0]          halt_cause,
  output logic [CH_W-1:0]     halt_ch,
  output logic [XLEN-1:0]     halt_pc,
  output logic [CYC_W-1:0]    cycle_count
);

  localparam logic [2:0] CAUSE_NONE    = 3'd0;
  localparam logic [2:0] CAUSE_ECALL   = 3'd1;
  localparam logic [2:0] CAUSE_EBREAK  = 3'd2;
  localparam logic [2:0] CAUSE_STUCK   = 3'd3;
  localparam logic [2:0] CAUSE_TIMEOUT = 3'd4;

  localparam bit               STUCK_EN  = (STUCK_LIMIT != 64'd0);
  localparam bit               TO_EN     = (TIMEOUT != 64'd0);
  localparam logic [STUCK_W-1:0] STUCK_LAST = STUCK_W'(STUCK_LIMIT - 64'd1);
  localparam logic [CYC_W-1:0]   TO_LAST    = CYC_W'(TIMEOUT - 64'd1);

  // A limit the stuck counter can never reach would silently disable detection.
  if (STUCK_LIMIT > ((64'd1 << STUCK_W) - 64'd1)) begin : g_bad_stuck_limit
    $error("run_monitor: STUCK_LIMIT exceeds the STUCK_W counter range");
  end

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_HALTED = 2'd2
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;

  logic [XLEN-1:0]     r_last_pc   [NCH];
  logic [STUCK_W-1:0]  r_stuck_cnt [NCH];
  logic [CYC_W-1:0]    r_cycle_count;
  logic                r_running;
  logic                r_halted;
  logic                r_halt_pulse;
  logic [2:0]          r_halt_cause;
  logic [CH_W-1:0]     r_halt_ch;
  logic [XLEN-1:0]     r_halt_pc;

  logic [NCH-1:0]      w_progress;
  logic [NCH-1:0]      w_stuck_trip;
  logic                w_timeout_trip;
  logic                w_trip;
  logic [2:0]          w_cause;
  logic [CH_W-1:0]     w_ch;
  logic [XLEN-1:0]     w_pc;

  // Per-channel progress and stuck detection from current inputs and counters
  always_comb begin
    w_progress   = '0;
    w_stuck_trip = '0;
    for (int i = 0; i < int'(NCH); i++) begin
      w_progress[i]   = ch_valid[i] && (ch_pc[i*XLEN +: XLEN] != r_last_pc[i]);
      w_stuck_trip[i] = STUCK_EN && (r_stuck_cnt[i] == STUCK_LAST) && !w_progress[i];
    end
    w_timeout_trip = TO_EN && (r_cycle_count == TO_LAST);
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next state and trip arbitration: EBREAK > ECALL > STUCK (lowest channel) > TIMEOUT
  always_comb begin
    w_state_nxt = r_state;
    w_cause     = CAUSE_NONE;
    w_ch        = '0;
    w_pc        = '0;
    w_trip      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (start) w_state_nxt = ST_RUN;
      end
      ST_RUN: begin
        if (ebreak_pulse) begin
          w_cause = CAUSE_EBREAK;
          w_pc    = ev_pc;
        end else if (ecall_pulse) begin
          w_cause = CAUSE_ECALL;
          w_pc    = ev_pc;
        end else if (|w_stuck_trip) begin
          w_cause = CAUSE_STUCK;
          for (int i = int'(NCH) - 1; i >= 0; i--) begin
            if (w_stuck_trip[i]) begin
              w_ch = CH_W'(i);
              w_pc = r_last_pc[i];
            end
          end
        end else if (w_timeout_trip) begin
          w_cause = CAUSE_TIMEOUT;
          w_pc    = ch_pc[XLEN-1:0];
        end
        w_trip = (w_cause != CAUSE_NONE);
        if (w_trip) w_state_nxt = ST_HALTED;
      end
      ST_HALTED: begin
        if (clear) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Counters, per-channel trackers and the halt record
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cycle_count <= '0;
      r_running     <= 1'b0;
      r_halted      <= 1'b0;
      r_halt_pulse  <= 1'b0;
      r_halt_cause  <= CAUSE_NONE;
      r_halt_ch     <= '0;
      r_halt_pc     <= '0;
      for (int i = 0; i < int'(NCH); i++) begin
        r_last_pc[i]   <= '0;
        r_stuck_cnt[i] <= '0;
      end
    end else begin
      r_running    <= (w_state_nxt == ST_RUN);
      r_halted     <= (w_state_nxt == ST_HALTED);
      r_halt_pulse <= w_trip;
      if (r_state == ST_IDLE && start) begin
        r_cycle_count <= '0;
        r_halt_cause  <= CAUSE_NONE;
        r_halt_ch     <= '0;
        r_halt_pc     <= '0;
        for (int i = 0; i < int'(NCH); i++) begin
          r_last_pc[i]   <= '0;
          r_stuck_cnt[i] <= '0;
        end
      end else if (r_state == ST_RUN) begin
        if (r_cycle_count != '1) r_cycle_count <= r_cycle_count + CYC_W'(1);
        for (int i = 0; i < int'(NCH); i++) begin
          if (w_progress[i]) begin
            r_last_pc[i]   <= ch_pc[i*XLEN +: XLEN];
            r_stuck_cnt[i] <= '0;
          end else if (r_stuck_cnt[i] != '1) begin
            r_stuck_cnt[i] <= r_stuck_cnt[i] + STUCK_W'(1);
          end
        end
        if (w_trip) begin
          r_halt_cause <= w_cause;
          r_halt_ch    <= w_ch;
          r_halt_pc    <= w_pc;
        end
      end
    end
  end

  assign running     = r_running;
  assign halted      = r_halted;
  assign halt_pulse  = r_halt_pulse;
  assign halt_cause  = r_halt_cause;
  assign halt_ch     = r_halt_ch;
  assign halt_pc     = r_halt_pc;
  assign cycle_count = r_cycle_count;

endmodule

// File: tb/tb_run_monitor.sv
// Directed bench for run_monitor: one instance with stuck detection, one with a run timeout.
module tb_run_monitor;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned NCH   = 3;
  localparam int unsigned CYC_W = 64;

  logic                clk = 1'b0;
  logic                rst, start_a, start_b, clear, ecall_pulse, ebreak_pulse;
  logic [XLEN-1:0]     ev_pc, pc0, pc1, pc2;
  logic [NCH-1:0]      ch_valid;
  logic [NCH*XLEN-1:0] ch_pc;

  logic                a_running, a_halted, a_halt_pulse;
  logic [2:0]          a_halt_cause;
  logic [1:0]          a_halt_ch;
  logic [XLEN-1:0]     a_halt_pc;
  logic [CYC_W-1:0]    a_cycle_count;
  logic                b_running, b_halted, b_halt_pulse;
  logic [2:0]          b_halt_cause;
  logic [1:0]          b_halt_ch;
  logic [XLEN-1:0]     b_halt_pc;
  logic [CYC_W-1:0]    b_cycle_count;

  int n_total = 0;
  int n_bad   = 0;

  assign ch_pc = {pc2, pc1, pc0};
  always #5 clk = ~clk;

  run_monitor #(.XLEN(XLEN), .NCH(NCH), .STUCK_W(24), .STUCK_LIMIT(16),
                .CYC_W(CYC_W), .TIMEOUT(0)) u_dut_a (
    .clk(clk), .rst(rst), .start(start_a), .clear(clear), .ch_pc(ch_pc),
    .ch_valid(ch_valid), .ecall_pulse(ecall_pulse), .ebreak_pulse(ebreak_pulse),
    .ev_pc(ev_pc), .running(a_running), .halted(a_halted), .halt_pulse(a_halt_pulse),
    .halt_cause(a_halt_cause), .halt_ch(a_halt_ch), .halt_pc(a_halt_pc),
    .cycle_count(a_cycle_count)
  );

  run_monitor #(.XLEN(XLEN), .NCH(NCH), .STUCK_W(24), .STUCK_LIMIT(0),
                .CYC_W(CYC_W), .TIMEOUT(100)) u_dut_b (
    .clk(clk), .rst(rst), .start(start_b), .clear(clear), .ch_pc(ch_pc),
    .ch_valid(ch_valid), .ecall_pulse(ecall_pulse), .ebreak_pulse(ebreak_pulse),
    .ev_pc(ev_pc), .running(b_running), .halted(b_halted), .halt_pulse(b_halt_pulse),
    .halt_cause(b_halt_cause), .halt_ch(b_halt_ch), .halt_pc(b_halt_pc),
    .cycle_count(b_cycle_count)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // All channels valid with distinct, advancing PCs
  task automatic prog(input int k);
    ch_valid = 3'b111;
    pc0 = 32'(4 * k);
    pc1 = 32'h0000_4000 + 32'(4 * k);
    pc2 = 32'h0000_8000 + 32'(4 * k);
  endtask

  task automatic do_clear();
    clear = 1'b1;
    tick();
    clear = 1'b0;
  endtask

  logic [2:0]      t3_cause [3] = '{3'd2, 3'd1, 3'd3};
  logic [XLEN-1:0] t3_pc    [3] = '{32'h200, 32'h200, 32'h0};

  initial begin
    rst = 1'b1; start_a = 1'b0; start_b = 1'b0; clear = 1'b0;
    ecall_pulse = 1'b0; ebreak_pulse = 1'b0; ev_pc = '0;
    pc0 = '0; pc1 = '0; pc2 = '0; ch_valid = '0;
    tick(); tick();
    chk("rst_running", a_running, 0);
    chk("rst_halted", a_halted, 0);
    chk("rst_cause", a_halt_cause, 0);
    chk("rst_count", a_cycle_count, 0);
    chk("rst_b_cause", b_halt_cause, 0);
    rst = 1'b0;

    // 1: EBREAK on RUN cycle 10
    start_a = 1'b1; tick(); start_a = 1'b0;
    chk("t1_running", a_running, 1);
    chk("t1_count0", a_cycle_count, 0);
    for (int k = 1; k <= 10; k++) begin
      prog(k);
      pc0 = 32'(4 * (k - 1));
      if (k == 10) begin ebreak_pulse = 1'b1; ev_pc = 32'h80; end
      tick();
      if (k == 9) chk("t1_not_yet", a_halted, 0);
    end
    ebreak_pulse = 1'b0;
    chk("t1_halted", a_halted, 1);
    chk("t1_pulse", a_halt_pulse, 1);
    chk("t1_cause", a_halt_cause, 2);
    chk("t1_pc", a_halt_pc, 32'h80);
    chk("t1_count", a_cycle_count, 10);
    chk("t1_run_off", a_running, 0);
    tick();
    chk("t1_pulse_off", a_halt_pulse, 0);
    chk("t1_frozen", a_cycle_count, 10);
    do_clear();
    chk("t1_clr_halted", a_halted, 0);
    chk("t1_keep_cause", a_halt_cause, 2);

    // 2: channel 1 stuck at 0x1000 from RUN cycle 3
    start_a = 1'b1; tick(); start_a = 1'b0;
    chk("t2_cause_cleared", a_halt_cause, 0);
    for (int k = 1; k <= 19; k++) begin
      prog(k);
      pc1 = (k <= 2) ? 32'h0F00 + 32'(4 * k) : 32'h1000;
      tick();
      if (k == 18) chk("t2_not_yet", a_halted, 0);
    end
    chk("t2_pulse", a_halt_pulse, 1);
    chk("t2_cause", a_halt_cause, 3);
    chk("t2_ch", a_halt_ch, 1);
    chk("t2_pc", a_halt_pc, 32'h1000);
    chk("t2_count", a_cycle_count, 19);
    tick();
    chk("t2_pulse_once", a_halt_pulse, 0);
    chk("t2_halted", a_halted, 1);
    start_a = 1'b1; tick(); start_a = 1'b0;
    chk("t2_start_ignored", a_halted, 1);
    do_clear();

    // 3: ch0 stuck trip coinciding with EBREAK+ECALL, ECALL only, and nothing else
    for (int v = 0; v < 3; v++) begin
      start_a = 1'b1; tick(); start_a = 1'b0;
      for (int k = 1; k <= 16; k++) begin
        prog(k);
        ch_valid[0] = 1'b0;
        if (k == 16) begin
          ecall_pulse  = (v < 2);
          ebreak_pulse = (v == 0);
          ev_pc        = 32'h200;
        end
        tick();
        if (k == 15) chk("t3_not_yet", a_halted, 0);
      end
      ecall_pulse = 1'b0; ebreak_pulse = 1'b0;
      chk("t3_halted", a_halted, 1);
      chk("t3_cause", a_halt_cause, t3_cause[v]);
      chk("t3_pc", a_halt_pc, t3_pc[v]);
      chk("t3_ch", a_halt_ch, 0);
      chk("t3_count", a_cycle_count, 16);
      do_clear();
    end

    // 5: 15 bubbles then a new PC restarts the stuck count
    start_a = 1'b1; tick(); start_a = 1'b0;
    for (int k = 1; k <= 31; k++) begin
      prog(k);
      if (k <= 15) ch_valid[0] = 1'b0;
      else         pc0 = 32'h40;
      tick();
      if (k == 16) chk("t5_no_halt16", a_halted, 0);
    end
    chk("t5_no_halt31", a_halted, 0);
    chk("t5_count31", a_cycle_count, 31);
    prog(32); pc0 = 32'h40;
    tick();
    chk("t5_cause", a_halt_cause, 3);
    chk("t5_ch", a_halt_ch, 0);
    chk("t5_pc", a_halt_pc, 32'h40);

    // 6: clear beats start; events in IDLE ignored; rst aborts a run
    clear = 1'b1; start_a = 1'b1; tick(); clear = 1'b0; start_a = 1'b0;
    chk("t6_idle_run", a_running, 0);
    chk("t6_idle_halted", a_halted, 0);
    chk("t6_keep_cause", a_halt_cause, 3);
    ebreak_pulse = 1'b1; ev_pc = 32'h999; tick(); ebreak_pulse = 1'b0;
    chk("t6_idle_event", a_halt_cause, 3);
    chk("t6_idle_pc", a_halt_pc, 32'h40);
    start_a = 1'b1; tick(); start_a = 1'b0;
    chk("t6_restart_cause", a_halt_cause, 0);
    chk("t6_restart_run", a_running, 1);
    for (int k = 1; k <= 5; k++) begin
      prog(k);
      tick();
    end
    chk("t6_count5", a_cycle_count, 5);
    rst = 1'b1; tick(); rst = 1'b0;
    chk("t6_rst_running", a_running, 0);
    chk("t6_rst_halted", a_halted, 0);
    chk("t6_rst_pulse", a_halt_pulse, 0);
    chk("t6_rst_count", a_cycle_count, 0);
    chk("t6_rst_cause", a_halt_cause, 0);
    chk("t6_rst_pc", a_halt_pc, 0);

    // 4: frozen PCs, timeout at 100 run cycles, stuck detection off
    ch_valid = 3'b111; pc0 = 32'h300; pc1 = 32'h300; pc2 = 32'h300;
    start_b = 1'b1; tick(); start_b = 1'b0;
    for (int k = 1; k <= 100; k++) begin
      tick();
      if (k == 99) begin
        chk("t4_not_yet", b_halted, 0);
        chk("t4_count99", b_cycle_count, 99);
      end
    end
    chk("t4_pulse", b_halt_pulse, 1);
    chk("t4_cause", b_halt_cause, 4);
    chk("t4_pc", b_halt_pc, 32'h300);
    chk("t4_ch", b_halt_ch, 0);
    chk("t4_count", b_cycle_count, 100);
    chk("t4_a_idle", a_halted, 0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
